// File: rtl/mips_mc_pkg.sv
// rtl/mips_mc_pkg.sv - opcodes, state encoding and datapath select encodings for the multi-cycle controller
package mips_mc_pkg;

  localparam logic [5:0] OP_R      = 6'd0;
  localparam logic [5:0] OP_J      = 6'd2;
  localparam logic [5:0] OP_BEQ    = 6'd4;
  localparam logic [5:0] OP_ORI    = 6'd13;
  localparam logic [5:0] OP_JSPAL  = 6'd19;
  localparam logic [5:0] OP_BALN   = 6'd27;
  localparam logic [5:0] OP_BLTZAL = 6'd34;
  localparam logic [5:0] OP_LW     = 6'd35;
  localparam logic [5:0] OP_SW     = 6'd43;

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC,
    RWB, BEQ, JUMP, ORIEX, ORIWB, BRLINK, JLINK
  } state_e;

  localparam logic [1:0] SRCB_B      = 2'd0;
  localparam logic [1:0] SRCB_4      = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMM_SH = 2'd3;

  localparam logic [1:0] ALU_ADD   = 2'd0;
  localparam logic [1:0] ALU_SUB   = 2'd1;
  localparam logic [1:0] ALU_FUNCT = 2'd2;
  localparam logic [1:0] ALU_OR    = 2'd3;

  localparam logic [1:0] PCS_ALU    = 2'd0;
  localparam logic [1:0] PCS_ALUOUT = 2'd1;
  localparam logic [1:0] PCS_JUMP   = 2'd2;
  localparam logic [1:0] PCS_REGA   = 2'd3;

  localparam logic [1:0] BR_ZERO  = 2'd0;
  localparam logic [1:0] BR_NEG   = 2'd1;
  localparam logic [1:0] BR_NFLAG = 2'd2;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwrite_cond;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       memtoreg;
    logic       regdst;
    logic       regwrite;
    logic       alusrca;
    logic       link;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsource;
    logic [1:0] brsel;
    logic       illegal_op;
    logic       mem_err;
  } ctrl_t;

endpackage

// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - opcode/mem handshake in, datapath control strobes out
interface multicycle_control_if #(parameter int OPW = 6);

  logic [OPW-1:0] op;
  logic           mem_ready;
  logic           pcwrite, pcwrite_cond, iord, memread, memwrite, irwrite;
  logic           memtoreg, regdst, regwrite, alusrca, link;
  logic [1:0]     alusrcb, aluop, pcsource, brsel;
  logic           illegal_op, mem_err;
  logic [3:0]     state;

  modport master (
    output op, mem_ready,
    input  pcwrite, pcwrite_cond, iord, memread, memwrite, irwrite,
    input  memtoreg, regdst, regwrite, alusrca, link,
    input  alusrcb, aluop, pcsource, brsel, illegal_op, mem_err, state
  );

  modport slave (
    input  op, mem_ready,
    output pcwrite, pcwrite_cond, iord, memread, memwrite, irwrite,
    output memtoreg, regdst, regwrite, alusrca, link,
    output alusrcb, aluop, pcsource, brsel, illegal_op, mem_err, state
  );

endinterface

// File: rtl/mem_wait_timer.sv
// rtl/mem_wait_timer.sv - counts mem_ready wait cycles; expired marks the TMO-th consecutive wait cycle
module mem_wait_timer #(
  parameter int TMO = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic waiting,
  output logic expired
);

  localparam int W = $clog2(TMO + 1);
  localparam logic [W-1:0] LAST = W'(TMO - 1);

  logic [W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr)
      count_d = '0;
    else if (waiting)
      count_d = count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      count_q <= '0;
    else
      count_q <= count_d;
  end

  // Combinational so the abort lands in the last wait cycle, not one after it.
  assign expired = waiting && (count_q == LAST);

endmodule

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multi-cycle MIPS-lite control FSM with bounded memory wait
module multicycle_control
  import mips_mc_pkg::*;
#(
  parameter int OPW = 6,
  parameter int TMO = 15
) (
  input  logic                 clk,
  input  logic                 reset,
  multicycle_control_if.slave  bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl, ctrl_g;
  logic   waiting, expired;

  assign waiting = (state_q inside {FETCH, MEMRD, MEMWR}) && !bus.mem_ready;

  mem_wait_timer #(.TMO(TMO)) u_timer (
    .clk     (clk),
    .rst     (reset),
    .clr     (!waiting || expired),
    .waiting (waiting),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state_q <= FETCH;
    else
      state_q <= state_d;
  end

  always_comb begin
    ctrl    = '0;
    state_d = state_q;
    case (state_q)
      FETCH: begin
        ctrl.memread = 1'b1;
        ctrl.alusrcb = SRCB_4;
        ctrl.irwrite = bus.mem_ready;
        ctrl.pcwrite = bus.mem_ready;
        if (bus.mem_ready)
          state_d = DECODE;
        else if (expired)
          ctrl.mem_err = 1'b1;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMM_SH;
        case (bus.op)
          OPW'(OP_LW), OPW'(OP_SW):      state_d = MEMADR;
          OPW'(OP_R):                    state_d = EXEC;
          OPW'(OP_BEQ):                  state_d = BEQ;
          OPW'(OP_J):                    state_d = JUMP;
          OPW'(OP_ORI):                  state_d = ORIEX;
          OPW'(OP_BLTZAL), OPW'(OP_BALN): state_d = BRLINK;
          OPW'(OP_JSPAL):                state_d = JLINK;
          default: begin
            ctrl.illegal_op = 1'b1;
            state_d         = FETCH;
          end
        endcase
      end
      MEMADR: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        if (bus.op == OPW'(OP_LW))
          state_d = MEMRD;
        else if (bus.op == OPW'(OP_SW))
          state_d = MEMWR;
        else
          state_d = FETCH;
      end
      MEMRD: begin
        ctrl.memread = 1'b1;
        ctrl.iord    = 1'b1;
        if (bus.mem_ready)
          state_d = MEMWB;
        else if (expired) begin
          ctrl.mem_err = 1'b1;
          state_d      = FETCH;
        end
      end
      MEMWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.memtoreg = 1'b1;
        state_d       = FETCH;
      end
      MEMWR: begin
        ctrl.memwrite = 1'b1;
        ctrl.iord     = 1'b1;
        if (bus.mem_ready)
          state_d = FETCH;
        else if (expired) begin
          ctrl.mem_err = 1'b1;
          state_d      = FETCH;
        end
      end
      EXEC: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALU_FUNCT;
        state_d      = RWB;
      end
      RWB: begin
        ctrl.regwrite = 1'b1;
        ctrl.regdst   = 1'b1;
        state_d       = FETCH;
      end
      BEQ: begin
        ctrl.alusrca      = 1'b1;
        ctrl.aluop        = ALU_SUB;
        ctrl.pcwrite_cond = 1'b1;
        ctrl.brsel        = BR_ZERO;
        ctrl.pcsource     = PCS_ALUOUT;
        state_d           = FETCH;
      end
      JUMP: begin
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCS_JUMP;
        state_d       = FETCH;
      end
      ORIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALU_OR;
        state_d      = ORIWB;
      end
      ORIWB: begin
        ctrl.regwrite = 1'b1;
        state_d       = FETCH;
      end
      BRLINK: begin
        ctrl.regwrite     = 1'b1;
        ctrl.link         = 1'b1;
        ctrl.pcwrite_cond = 1'b1;
        ctrl.pcsource     = PCS_ALUOUT;
        ctrl.brsel        = (bus.op == OPW'(OP_BLTZAL)) ? BR_NEG : BR_NFLAG;
        state_d           = FETCH;
      end
      JLINK: begin
        ctrl.regwrite = 1'b1;
        ctrl.link     = 1'b1;
        ctrl.pcwrite  = 1'b1;
        ctrl.pcsource = PCS_REGA;
        state_d       = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Reset kills every strobe at once, including the FETCH memread.
  assign ctrl_g = reset ? '0 : ctrl;

  assign bus.pcwrite      = ctrl_g.pcwrite;
  assign bus.pcwrite_cond = ctrl_g.pcwrite_cond;
  assign bus.iord         = ctrl_g.iord;
  assign bus.memread      = ctrl_g.memread;
  assign bus.memwrite     = ctrl_g.memwrite;
  assign bus.irwrite      = ctrl_g.irwrite;
  assign bus.memtoreg     = ctrl_g.memtoreg;
  assign bus.regdst       = ctrl_g.regdst;
  assign bus.regwrite     = ctrl_g.regwrite;
  assign bus.alusrca      = ctrl_g.alusrca;
  assign bus.link         = ctrl_g.link;
  assign bus.alusrcb      = ctrl_g.alusrcb;
  assign bus.aluop        = ctrl_g.aluop;
  assign bus.pcsource     = ctrl_g.pcsource;
  assign bus.brsel        = ctrl_g.brsel;
  assign bus.illegal_op   = ctrl_g.illegal_op;
  assign bus.mem_err      = ctrl_g.mem_err;
  assign bus.state        = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - scoreboard bench for multicycle_control
module tb_multicycle_control;
  import mips_mc_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  multicycle_control_if #(.OPW(6)) bus ();

  multicycle_control #(.OPW(6), .TMO(15)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  localparam logic [20:0] PCW  = 21'd1 << 20;
  localparam logic [20:0] PCWC = 21'd1 << 19;
  localparam logic [20:0] IORD = 21'd1 << 18;
  localparam logic [20:0] MRD  = 21'd1 << 17;
  localparam logic [20:0] MWR  = 21'd1 << 16;
  localparam logic [20:0] IRW  = 21'd1 << 15;
  localparam logic [20:0] M2R  = 21'd1 << 14;
  localparam logic [20:0] RDST = 21'd1 << 13;
  localparam logic [20:0] RW   = 21'd1 << 12;
  localparam logic [20:0] SRCA = 21'd1 << 11;
  localparam logic [20:0] LNK  = 21'd1 << 10;
  localparam logic [20:0] ILL  = 21'd2;
  localparam logic [20:0] MERR = 21'd1;

  function automatic logic [20:0] srcb(input int v); return 21'(v) << 8; endfunction
  function automatic logic [20:0] aop(input int v);  return 21'(v) << 6; endfunction
  function automatic logic [20:0] pcs(input int v);  return 21'(v) << 4; endfunction
  function automatic logic [20:0] brs(input int v);  return 21'(v) << 2; endfunction

  localparam logic [20:0] F_RDY  = PCW | IRW | MRD | (21'd1 << 8);
  localparam logic [20:0] F_WAIT = MRD | (21'd1 << 8);
  localparam logic [20:0] DEC    = 21'd3 << 8;
  localparam logic [20:0] MADR   = SRCA | (21'd2 << 8);

  logic [20:0] cur_o;
  assign cur_o = {bus.pcwrite, bus.pcwrite_cond, bus.iord, bus.memread, bus.memwrite,
                  bus.irwrite, bus.memtoreg, bus.regdst, bus.regwrite, bus.alusrca, bus.link,
                  bus.alusrcb, bus.aluop, bus.pcsource, bus.brsel, bus.illegal_op, bus.mem_err};

  typedef struct {
    int          id;
    logic [3:0]  st;
    logic [20:0] o;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   step_id = 0;

  event        direct_ev;
  int          dreq = 0;
  int          dseen = 0;
  int          dkind, dtag;
  logic [3:0]  dst;
  logic [20:0] dexp;

  always begin : monitor
    exp_t e;
    @(negedge clk or direct_ev);
    if (dreq != dseen) begin
      dseen = dreq;
      checks++;
      if (dkind == 1) begin
        if (q.size() != 0) begin
          errors++;
          $display("FAIL queue_drain: %0d entries left, required 0", q.size());
        end
      end else if (bus.state !== dst || cur_o !== dexp) begin
        errors++;
        $display("FAIL direct_%0d: state=%0d out=%h, required state=%0d out=%h",
                 dtag, bus.state, cur_o, dst, dexp);
      end
    end else if (!reset && q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if (bus.state !== e.st || cur_o !== e.o) begin
        errors++;
        $display("FAIL step_%0d: state=%0d out=%h, required state=%0d out=%h",
                 e.id, bus.state, cur_o, e.st, e.o);
      end
    end
  end

  task automatic dcheck(input int kind, input int tag, input logic [3:0] st, input logic [20:0] o);
    dkind = kind;
    dtag  = tag;
    dst   = st;
    dexp  = o;
    dreq++;
    -> direct_ev;
    #0;
  endtask

  task automatic step(input logic [5:0] op, input logic mr, input state_e st, input logic [20:0] o);
    exp_t e;
    bus.op        = op;
    bus.mem_ready = mr;
    e.id = step_id;
    e.st = st;
    e.o  = o;
    q.push_back(e);
    step_id++;
    @(posedge clk);
    #1;
  endtask

  task automatic fd(input logic [5:0] op);
    step(op, 1'b1, FETCH, F_RDY);
    step(op, 1'b1, DECODE, DEC);
  endtask

  task automatic r_type();
    fd(OP_R);
    step(OP_R, 1'b1, EXEC, SRCA | aop(2));
    step(OP_R, 1'b1, RWB, RW | RDST);
  endtask

  initial begin
    reset         = 1'b1;
    bus.op        = OP_R;
    bus.mem_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    dcheck(0, 0, FETCH, 21'd0);
    reset = 1'b0;

    r_type();

    // lw with three wait cycles in MEMRD
    fd(OP_LW);
    step(OP_LW, 1'b1, MEMADR, MADR);
    repeat (3) step(OP_LW, 1'b0, MEMRD, MRD | IORD);
    step(OP_LW, 1'b1, MEMRD, MRD | IORD);
    step(OP_LW, 1'b1, MEMWB, RW | M2R);

    fd(OP_SW);
    step(OP_SW, 1'b1, MEMADR, MADR);
    step(OP_SW, 1'b1, MEMWR, MWR | IORD);

    fd(OP_BEQ);
    step(OP_BEQ, 1'b1, BEQ, SRCA | aop(1) | PCWC | pcs(1));

    fd(OP_J);
    step(OP_J, 1'b1, JUMP, PCW | pcs(2));

    fd(OP_ORI);
    step(OP_ORI, 1'b1, ORIEX, SRCA | srcb(2) | aop(3));
    step(OP_ORI, 1'b1, ORIWB, RW);

    fd(OP_BLTZAL);
    step(OP_BLTZAL, 1'b1, BRLINK, RW | LNK | PCWC | pcs(1) | brs(1));
    fd(OP_BALN);
    step(OP_BALN, 1'b1, BRLINK, RW | LNK | PCWC | pcs(1) | brs(2));

    fd(OP_JSPAL);
    step(OP_JSPAL, 1'b1, JLINK, RW | LNK | PCW | pcs(3));

    step(6'd63, 1'b1, FETCH, F_RDY);
    step(6'd63, 1'b1, DECODE, DEC | ILL);

    // FETCH timeout: error in wait cycle 15, fetch re-issued with a fresh timer
    repeat (14) step(OP_R, 1'b0, FETCH, F_WAIT);
    step(OP_R, 1'b0, FETCH, F_WAIT | MERR);
    step(OP_R, 1'b0, FETCH, F_WAIT);
    r_type();

    // ready arriving in the 15th wait cycle completes the load
    fd(OP_LW);
    step(OP_LW, 1'b1, MEMADR, MADR);
    repeat (14) step(OP_LW, 1'b0, MEMRD, MRD | IORD);
    step(OP_LW, 1'b1, MEMRD, MRD | IORD);
    step(OP_LW, 1'b1, MEMWB, RW | M2R);

    // load timeout skips MEMWB
    fd(OP_LW);
    step(OP_LW, 1'b1, MEMADR, MADR);
    repeat (14) step(OP_LW, 1'b0, MEMRD, MRD | IORD);
    step(OP_LW, 1'b0, MEMRD, MRD | IORD | MERR);
    r_type();

    // store timeout
    fd(OP_SW);
    step(OP_SW, 1'b1, MEMADR, MADR);
    repeat (14) step(OP_SW, 1'b0, MEMWR, MWR | IORD);
    step(OP_SW, 1'b0, MEMWR, MWR | IORD | MERR);
    r_type();

    // asynchronous reset in the middle of a store
    fd(OP_SW);
    step(OP_SW, 1'b1, MEMADR, MADR);
    bus.mem_ready = 1'b0;
    #1;
    dcheck(0, 1, MEMWR, MWR | IORD);
    reset = 1'b1;
    #1;
    dcheck(0, 2, FETCH, 21'd0);
    @(posedge clk);
    #1;
    dcheck(0, 3, FETCH, 21'd0);
    reset = 1'b0;
    #1;
    dcheck(0, 4, FETCH, F_WAIT);
    r_type();

    @(posedge clk);
    #1;
    dcheck(1, 5, 4'd0, 21'd0);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Multi-cycle successor to the single-cycle MIPS-lite control decoder: a Moore/Mealy FSM that sequences each instruction over 2–5 states, and waits on a memory ready handshake with a bounded timeout. It sits between the instruction register opcode field and the multi-cycle datapath (shared memory, IR, A/B/ALUOut registers). It covers R-type, lw, sw, beq, j, ori, bltzal, jspal and baln, and flags illegal opcodes.

## Interface
- OPW, 6: opcode width; opcode constants are zero-extended to OPW.
- TMO, 15: maximum wait cycles on mem_ready before abort (≥1).
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-high.
- op  in  OPW  opcode from IR.
- mem_ready  in  1  memory has completed the current access.
- pcwrite, pcwrite_cond, iord, memread, memwrite, irwrite, memtoreg, regdst, regwrite, alusrca, link  out  1 each  datapath strobes/selects; link=1 selects $31 as destination and PC+4 as write data.
- alusrcb  out  2  0:B, 1:4, 2:signext imm, 3:signext imm<<2.
- aluop  out  2  0:add, 1:sub, 2:funct, 3:or.
- pcsource  out  2  0:ALU, 1:ALUOut, 2:jump target, 3:register A.
- brsel  out  2  branch condition for pcwrite_cond: 0:zero, 1:A<0, 2:N flag.
- illegal_op, mem_err  out  1  single-cycle pulses.
- state  out  4  current state, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, RWB, BEQ, JUMP, ORIEX, ORIWB, BRLINK, JLINK.
- FETCH: memread=1, iord=0, alusrca=0, alusrcb=1, aluop=0, pcsource=0. irwrite and pcwrite = mem_ready. Advances to DECODE when mem_ready=1.
- DECODE: alusrcb=3, aluop=0. Dispatch: lw/sw→MEMADR; R(0)→EXEC; beq(4)→BEQ; j(2)→JUMP; ori(13)→ORIEX; bltzal(34), baln(27)→BRLINK; jspal(19)→JLINK. Any other opcode pulses illegal_op and goes to FETCH.
- MEMADR: alusrca=1, alusrcb=2, aluop=0. Goes to MEMRD for lw(35), MEMWR for sw(43).
- MEMRD: memread=1, iord=1. On mem_ready goes to MEMWB. MEMWB: regwrite=1, memtoreg=1, regdst=0, then FETCH.
- MEMWR: memwrite=1, iord=1. On mem_ready goes to FETCH.
- EXEC: alusrca=1, alusrcb=0, aluop=2, then RWB. RWB: regwrite=1, regdst=1, then FETCH.
- BEQ: alusrca=1, alusrcb=0, aluop=1, pcwrite_cond=1, brsel=0, pcsource=1, then FETCH.
- ORIEX: alusrca=1, alusrcb=2 (zero-extend is handled by the datapath on ori), aluop=3, then ORIWB. ORIWB: regwrite=1, regdst=0, then FETCH.
- JUMP: pcwrite=1, pcsource=2, then FETCH.
- BRLINK: regwrite=1 and link=1 unconditionally; pcwrite_cond=1, pcsource=1; brsel=1 for bltzal, 2 for baln. Then FETCH.
- JLINK: regwrite=1, link=1, pcwrite=1, pcsource=3, then FETCH.
- Any output not listed for a state is 0.
- Wait timer: counts cycles spent in FETCH/MEMRD/MEMWR with mem_ready=0. Cleared on state entry and on mem_ready=1. When the count reaches TMO with mem_ready still 0: pulse mem_err, drop the access, go to FETCH (a FETCH timeout re-issues the fetch), and do not assert pcwrite/irwrite/regwrite.

## Timing
- While reset=1: state=FETCH, timer=0, all outputs forced to 0. The first memread rises in the cycle after reset falls.
- Reset asserted mid-instruction aborts it immediately; no partial writes are issued afterwards.
- Outputs are Moore decodes of state, except irwrite/pcwrite in FETCH, which are gated by mem_ready in the same cycle.
- Zero-wait cycle counts: lw 5; sw, R, ori 4; beq, j, bltzal, baln, jspal 3; illegal 2.
- Each wait cycle adds 1. An abort happens after exactly TMO wait cycles; mem_err is high in the last of them.
- mem_ready arriving in the same cycle the timer hits TMO: the access completes and no mem_err is raised.

## Structure
- Package mips_mc_pkg: opcode localparams, state enum (4-bit), aluop/alusrcb/pcsource/brsel encodings.
- One sub-module, mem_wait_timer: a clog2(TMO+1)-bit counter with inputs clr and waiting, output expired.
- The FSM next-state and output decode live in multicycle_control.

## Test plan
- Reset release with mem_ready tied 1, op=0 (R): state sequence FETCH, DECODE, EXEC, RWB, FETCH; regwrite=1 and regdst=1 only in RWB.
- lw (op=35) with mem_ready low for 3 cycles in MEMRD: MEMRD held 4 cycles; MEMWB has regwrite=1, memtoreg=1; no mem_err.
- mem_ready held 0 in FETCH with TMO=15: mem_err pulses at wait cycle 15; pcwrite and irwrite never asserted; fetch retried.
- bltzal (op=34), then baln (op=27): BRLINK with link=1, regwrite=1, pcwrite_cond=1; brsel=1, then brsel=2.
- Illegal op=63: illegal_op pulses for 1 cycle in DECODE; next state is FETCH; no write strobes.
- reset asserted during MEMWR with memwrite=1: memwrite drops to 0 asynchronously; after release, state is FETCH.
